// File: rtl/pad_pkg.sv
// Shared types and constants for the NES-style gamepad reader.
// Button bit positions follow the order bits arrive on the wire.
package pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } pad_state_t;

    typedef logic [7:0] btn_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the pad serial line.
// Resets to 1 so an idle line reads as "not pressed".
module pad_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_reader.sv
// Polls an NES-style pad over latch/clock and presents registered buttons.
// Define PAD_DEBOUNCE_EN to require two matching frames before updating.
module pad_reader
    import pad_pkg::*;
#(
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 833_333
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_data,
    output logic pad_latch,
    output logic pad_clk,
    output logic A,
    output logic B,
    output logic Select,
    output logic Start,
    output logic Up,
    output logic Down,
    output logic Left,
    output logic Right,
    output logic frame_valid
);

    localparam int PHW = $clog2(2 * CLK_DIV);
    localparam int PLW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [PHW-1:0] LATCH_LAST = PHW'(2 * CLK_DIV - 1);
    localparam logic [PHW-1:0] HALF_LAST  = PHW'(CLK_DIV - 1);
    localparam logic [PLW-1:0] POLL_LAST  = PLW'(POLL_PERIOD - 1);

    pad_state_t     state;
    logic [PHW-1:0] phase;
    logic [PLW-1:0] poll;
    logic [2:0]     idx;
    btn_t           cap;
    btn_t           btn;
    logic           data_sync;
    logic           pressed;
`ifdef PAD_DEBOUNCE_EN
    btn_t           prev;
`endif

    pad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_data),
        .q   (data_sync)
    );

    assign pressed = ~data_sync;

    // pad_latch/pad_clk are set on the transition into the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            poll        <= '0;
            idx         <= '0;
            cap         <= '0;
            btn         <= '0;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b1;
            frame_valid <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
            prev        <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll == POLL_LAST) begin
                        poll      <= '0;
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                    end else begin
                        poll <= poll + PLW'(1);
                    end
                end
                LATCH: begin
                    if (phase == LATCH_LAST) begin
                        phase     <= '0;
                        idx       <= '0;
                        state     <= LOW;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                    end else begin
                        phase <= phase + PHW'(1);
                    end
                end
                LOW: begin
                    if (phase == HALF_LAST) begin
                        phase    <= '0;
                        cap[idx] <= pressed;
                        state    <= HIGH;
                        pad_clk  <= 1'b1;
                    end else begin
                        phase <= phase + PHW'(1);
                    end
                end
                HIGH: begin
                    if (phase == HALF_LAST) begin
                        phase <= '0;
                        if (idx == 3'd7) begin
                            state <= DONE;
                        end else begin
                            idx     <= idx + 3'd1;
                            state   <= LOW;
                            pad_clk <= 1'b0;
                        end
                    end else begin
                        phase <= phase + PHW'(1);
                    end
                end
                DONE: begin
`ifdef PAD_DEBOUNCE_EN
                    if (cap == prev) btn <= cap;
                    prev <= cap;
`else
                    btn <= cap;
`endif
                    frame_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign A      = btn[BTN_A];
    assign B      = btn[BTN_B];
    assign Select = btn[BTN_SELECT];
    assign Start  = btn[BTN_START];
    assign Up     = btn[BTN_UP];
    assign Down   = btn[BTN_DOWN];
    assign Left   = btn[BTN_LEFT];
    assign Right  = btn[BTN_RIGHT];

endmodule

// File: tb/tb_pad_reader.sv
// Randomized scoreboard bench for pad_reader with a behavioural pad model.
// Honours PAD_DEBOUNCE_EN the same way as the design.
module tb_pad_reader;

    localparam int CLK_DIV   = 4;
    localparam int POLL      = 16;
    localparam int FRAME_LEN = 18 * CLK_DIV + 1;

    typedef struct {
        logic [7:0] btn;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pad_data = 1'b1;
    logic pad_latch, pad_clk, frame_valid;
    logic A, B, Select, Start, Up, Down, Left, Right;
    logic [7:0] got;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int latch_cyc = 0;
    int rel = 0;

    logic [7:0] pattern = 8'h00;
    logic [7:0] sr = 8'h00;
    logic       pm_prev_clk = 1'b1;
    logic [7:0] prev_pat = 8'h00;
    logic [7:0] exp_out = 8'h00;
    exp_t       q[$];

    pad_reader #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL)) dut (
        .clk         (clk),
        .rst         (rst),
        .pad_data    (pad_data),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .A           (A),
        .B           (B),
        .Select      (Select),
        .Start       (Start),
        .Up          (Up),
        .Down        (Down),
        .Left        (Left),
        .Right       (Right),
        .frame_valid (frame_valid)
    );

    assign got = {Right, Left, Down, Up, Start, Select, B, A};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Pad: loads while latched, shifts on pad_clk rise, drives active-low
    initial begin
        forever begin
            @(negedge clk);
            if (pad_latch) sr = pattern;
            else if (pad_clk && !pm_prev_clk) sr = sr >> 1;
            pm_prev_clk = pad_clk;
            pad_data = ~sr[0];
        end
    end

    // Monitor: scoreboard pops, output hold, and pad protocol shape
    initial begin
        logic [7:0] last_out;
        logic       prev_clk, prev_lat, overlap;
        int         falls, low_run, high_run;
        exp_t       e;
        last_out = 8'h00; prev_clk = 1'b1; prev_lat = 1'b0;
        overlap = 1'b0; falls = 0; low_run = 0; high_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_out = 8'h00; prev_clk = 1'b1; prev_lat = 1'b0;
                overlap = 1'b0; falls = 0; low_run = 0; high_run = 0;
            end else begin
                if (pad_latch && !prev_lat) begin
                    falls = 0;
                    overlap = 1'b0;
                end
                if (pad_latch && !pad_clk) overlap = 1'b1;
                if (!pad_clk && prev_clk) begin
                    falls++;
                    if (falls > 1)
                        check(high_run == CLK_DIV, "high_phase",
                              high_run, CLK_DIV);
                    low_run = 0;
                end
                if (pad_clk && !prev_clk) begin
                    check(low_run == CLK_DIV, "low_phase", low_run, CLK_DIV);
                    high_run = 0;
                end
                if (!pad_clk) low_run++;
                else high_run++;
                prev_clk = pad_clk;
                prev_lat = pad_latch;

                if (frame_valid) begin
                    check(falls == 8, "clk_falls", falls, 8);
                    check(!overlap, "latch_clk_overlap", overlap, 0);
                    if (q.size() == 0) begin
                        check(1'b0, "unexpected_frame_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check(got == e.btn, "buttons", got, e.btn);
                        check(cyc == e.cyc, "frame_valid_time", cyc, e.cyc);
                        last_out = e.btn;
                    end
                end else begin
                    check(got == last_out, "hold", got, last_out);
                end
            end
        end
    end

    task automatic wait_latch_rise(output bit ok);
        int n;
        n = 0;
        while (pad_latch && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!pad_latch && n < 400) begin @(negedge clk); n++; end
        ok = pad_latch;
        if (!ok) check(1'b0, "latch_timeout", 0, 1);
        latch_cyc = cyc;
    endtask

    task automatic push_frame(input logic [7:0] pat);
        exp_t e;
        pattern = pat;
`ifdef PAD_DEBOUNCE_EN
        if (pat == prev_pat) exp_out = pat;
        prev_pat = pat;
`else
        exp_out = pat;
`endif
        e.btn = exp_out;
        e.cyc = latch_cyc + FRAME_LEN;
        q.push_back(e);
    endtask

    task automatic run_frame(input logic [7:0] pat);
        bit ok;
        int w;
        wait_latch_rise(ok);
        if (ok) begin
            push_frame(pat);
            w = 0;
            while (pad_latch && w < 100) begin @(negedge clk); w++; end
            check(w == 2 * CLK_DIV, "latch_width", w, 2 * CLK_DIV);
        end
    endtask

    task automatic wait_fv();
        int n;
        n = 0;
        while (!frame_valid && n < 300) begin @(negedge clk); n++; end
        if (!frame_valid) check(1'b0, "frame_valid_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] pat;
        bit ok;
        int n;

        repeat (3) @(negedge clk);
        check(got == 8'h00, "rst_buttons", got, 0);
        check(pad_latch == 1'b0, "rst_latch", pad_latch, 0);
        check(pad_clk == 1'b1, "rst_pad_clk", pad_clk, 1);
        check(frame_valid == 1'b0, "rst_frame_valid", frame_valid, 0);
        rst = 1'b0;
        rel = cyc;

        run_frame(8'h5A);
        check(latch_cyc == rel + POLL, "first_latch", latch_cyc, rel + POLL);
        run_frame(8'h5A);
        wait_fv();
        check(got == 8'h5A, "pattern_5a", got, 8'h5A);

        run_frame(8'h00);
        run_frame(8'h00);
        run_frame(8'h01);
        wait_fv();
`ifdef PAD_DEBOUNCE_EN
        check(A == 1'b0, "glitch_A", A, 0);
`else
        check(A == 1'b1, "glitch_A", A, 1);
`endif
        run_frame(8'h00);
        run_frame(8'h01);
        run_frame(8'h01);
        wait_fv();
        check(A == 1'b1, "held_A", A, 1);

        pat = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) != 0) pat = 8'($urandom);
            run_frame(pat);
        end

        run_frame(8'hFF);
        run_frame(8'hFF);

        wait_latch_rise(ok);
        if (ok) begin
            pattern = 8'h3C;
            n = 0;
            while (cyc < latch_cyc + 33 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check(pad_clk == 1'b0, "mid_low_phase", pad_clk, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        prev_pat = 8'h00;
        exp_out = 8'h00;
        check(got == 8'h00, "midrst_buttons", got, 0);
        check(pad_latch == 1'b0, "midrst_latch", pad_latch, 0);
        check(pad_clk == 1'b1, "midrst_pad_clk", pad_clk, 1);
        check(frame_valid == 1'b0, "midrst_fv", frame_valid, 0);
        rst = 1'b0;
        rel = cyc;

        run_frame(8'h3C);
        check(latch_cyc == rel + POLL, "latch_after_rst", latch_cyc, rel + POLL);
        run_frame(8'h3C);

        n = 0;
        while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check(q.size() == 0, "drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_reader.md
# pad_reader

Serial gamepad front end for the Game of Life board. It polls an NES-style controller with a latch/clock protocol and deserialises the 8 button bits. It presents registered, active-high button levels (A, B, Select, Start, Up, Down, Left, Right) that feed directly into `grid`'s joystick inputs. It also emits a one-cycle `frame_valid` strobe per completed poll.

## Interface
- `CLK_DIV`, default 300: half-period of `pad_clk`, in `clk` cycles. Must be ≥ 4.
- `POLL_PERIOD`, default 833_333: number of IDLE cycles between polls. Must be ≥ 1.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `pad_data`, input, 1: serial data from the pad, active-low (0 = pressed). Asynchronous to `clk`.
- `pad_latch`, output, 1: parallel-load strobe to the pad, active-high.
- `pad_clk`, output, 1: shift clock to the pad. Idles high.
- `A`, `B`, `Select`, `Start`, `Up`, `Down`, `Left`, `Right`, output, 1 each: registered button levels, active-high.
- `frame_valid`, output, 1: one-cycle pulse marking the cycle in which the button outputs take a new frame's result.

## Operation
- `pad_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value, inverted, so 1 = pressed.
- Bit order on the wire, index 0..7: A, B, Select, Start, Up, Down, Left, Right.
- FSM states are IDLE, LATCH, LOW, HIGH and DONE.
  - IDLE: the poll counter increments each cycle. When it equals POLL_PERIOD-1, the counter clears and the FSM goes to LATCH.
  - LATCH: `pad_latch`=1 for exactly 2*CLK_DIV cycles, then go to LOW with bit index 0.
  - LOW: `pad_clk`=0 for CLK_DIV cycles. On the last LOW cycle, the synchronized data is written into shift bit [index]. Then go to HIGH.
  - HIGH: `pad_clk`=1 for CLK_DIV cycles. At the end, if index==7 go to DONE; otherwise increment index and go to LOW.
  - DONE: lasts 1 cycle. The capture register is transferred to the outputs (subject to the configuration below), `frame_valid`=1, then go to IDLE.
- `pad_latch` and `pad_clk` are driven from registers decoded from the next state, so they are glitch-free. `pad_latch` is 0 outside LATCH. `pad_clk` is 1 outside LOW.
- Phase counter width is $clog2(2*CLK_DIV). Poll counter width is $clog2(POLL_PERIOD). Bit index is 3 bits and never exceeds 7.
- Button outputs change only in DONE. They hold their value for the whole of the next frame.
- Reset values:
  - FSM in IDLE with all counters at 0.
  - `pad_latch`=0, `pad_clk`=1.
  - All button outputs 0, `frame_valid`=0.
  - Capture register and debounce register 0.
- Reset mid-frame: on the cycle after `rst` is sampled high, all outputs are at their reset values. Any partial capture is discarded. The next poll starts POLL_PERIOD cycles after `rst` deasserts.
- No pad connected (`pad_data` floating high): every frame reads all zeros, so all buttons read 0. `frame_valid` still pulses.

## Timing
- Frame length is 2*CLK_DIV + 16*CLK_DIV + 1 = 18*CLK_DIV + 1 cycles (LATCH through DONE).
- Poll period is POLL_PERIOD + 18*CLK_DIV + 1 cycles. With the defaults at 50 MHz this is about 60 Hz.
- The first LATCH cycle is exactly POLL_PERIOD cycles after the first cycle with `rst` low.
- Bit k is sampled 2*CLK_DIV + 2*k*CLK_DIV + CLK_DIV - 1 cycles after LATCH entry. Synchronizer latency is 2 cycles, so CLK_DIV ≥ 4 guarantees the data seen has settled for at least 2 cycles after the preceding `pad_clk` rise.
- Latency from a button change at the pad to the output is at most one poll period + frame length + 2 cycles. With the debounce feature compiled in, add one further poll period.

## Configuration
- `PAD_DEBOUNCE_EN` defined:
  - DONE updates the outputs only if the current capture equals the capture from the previous frame.
  - The previous-frame register is updated every DONE.
  - A single-frame glitch never reaches the outputs.
  - `frame_valid` pulses every DONE regardless of whether the outputs were updated.
- `PAD_DEBOUNCE_EN` undefined: DONE copies the capture to the outputs unconditionally, and no previous-frame register exists.

## Structure
- Package `pad_pkg` holds:
  - `pad_state_t`, the FSM enum.
  - `btn_t`, a logic [7:0] typedef.
  - Index constants BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7.
- One sub-module, `pad_sync`: a 2-flop synchronizer with a reset value of 1 (idle, not pressed).

## Test plan
All scenarios use a bench with CLK_DIV=4 and POLL_PERIOD=16; frame length = 73 cycles. The pad model shifts on `pad_clk` rising edges and loads on `pad_latch`.
- Reset: hold `rst` 3 cycles → all buttons 0, `pad_latch`=0, `pad_clk`=1, `frame_valid`=0. `pad_latch` rises exactly 16 cycles after `rst` drops and stays high 8 cycles.
- Pressed pattern 0x5A → after the first DONE, B=Start=Up=Left=1 and A=Select=Down=Right=0. `frame_valid` pulses once, 73 cycles after LATCH entry.
- Protocol shape: count `pad_clk` falling edges per frame → exactly 8, each low phase 4 cycles and each high phase 4 cycles. `pad_latch` and `pad_clk` are never active simultaneously.
- Reset mid-frame: assert `rst` during LOW of bit 3 → on the next cycle outputs are at their reset values. The held outputs are cleared. The next LATCH arrives 16 cycles after release.
- Debounce (with `PAD_DEBOUNCE_EN`): pattern 0x01 for one frame between 0x00 frames → A stays 0. Pattern 0x01 held for two frames → A=1 at the second DONE.
- No-debounce build with the same single-frame 0x01 → A=1 for exactly one poll period, then 0.
